// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the word at the PC, checks odd parity, absorbs
// the EXTEND prefix and presents opcode/operand to the decoder over valid/ready.
module instr_fetch #(
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [14:0] EXTEND_WORD = 15'o00006
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [11:0] pc_addr,
  output logic        pc_enable,
  input  logic        flush,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [2:0]  inst_opcode,
  output logic [11:0] inst_operand,
  output logic        inst_extended,
  output logic        parity_err,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ADV,
    S_HOLD,
    S_ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [11:0] addr_reg, addr_next;
  logic [15:0] data_reg, data_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        ext_pending_reg, ext_pending_next;
  logic [2:0]  opcode_reg, opcode_next;
  logic [11:0] operand_reg, operand_next;
  logic        extended_reg, extended_next;
  logic        parity_err_reg, parity_err_next;
  logic        timeout_err_reg, timeout_err_next;

  logic word_ok;
  logic is_extend;

  // AGC words carry odd parity over all 16 bits.
  assign word_ok   = ^data_reg;
  assign is_extend = (data_reg[14:0] == EXTEND_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      addr_reg        <= '0;
      data_reg        <= '0;
      cnt_reg         <= '0;
      ext_pending_reg <= 1'b0;
      opcode_reg      <= '0;
      operand_reg     <= '0;
      extended_reg    <= 1'b0;
      parity_err_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
      cnt_reg         <= cnt_next;
      ext_pending_reg <= ext_pending_next;
      opcode_reg      <= opcode_next;
      operand_reg     <= operand_next;
      extended_reg    <= extended_next;
      parity_err_reg  <= parity_err_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    data_next        = data_reg;
    cnt_next         = cnt_reg;
    ext_pending_next = ext_pending_reg;
    opcode_next      = opcode_reg;
    operand_next     = operand_reg;
    extended_next    = extended_reg;
    parity_err_next  = parity_err_reg;
    timeout_err_next = timeout_err_reg;

    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_REQ;
      end
      S_REQ: begin
        addr_next = pc_addr;
        cnt_next  = '0;
        if (flush) begin
          ext_pending_next = 1'b0;
          state_next       = S_REQ;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush outranks an ack arriving in the same cycle.
        if (flush) begin
          cnt_next         = '0;
          ext_pending_next = 1'b0;
          state_next       = S_REQ;
        end else if (mem_ack) begin
          data_next  = mem_data;
          cnt_next   = '0;
          state_next = S_ADV;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_err_next = 1'b1;
          state_next       = S_ERR;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_ADV: begin
        if (!word_ok) begin
          parity_err_next = 1'b1;
          state_next      = S_ERR;
        end else if (flush) begin
          ext_pending_next = 1'b0;
          state_next       = S_REQ;
        end else if (is_extend && !ext_pending_reg) begin
          ext_pending_next = 1'b1;
          state_next       = S_REQ;
        end else begin
          opcode_next      = data_reg[14:12];
          operand_next     = data_reg[11:0];
          extended_next    = ext_pending_reg;
          ext_pending_next = 1'b0;
          state_next       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          ext_pending_next = 1'b0;
          state_next       = S_REQ;
        end else if (inst_ready) begin
          state_next = run ? S_REQ : S_IDLE;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // In REQ the address is taken straight from the PC so it is valid alongside mem_req.
  assign mem_req       = (state_reg == S_REQ) || (state_reg == S_WAIT);
  assign mem_addr      = (state_reg == S_REQ) ? pc_addr : addr_reg;
  assign pc_enable     = (state_reg == S_ADV) && word_ok;
  assign inst_valid    = (state_reg == S_HOLD);
  assign inst_opcode   = opcode_reg;
  assign inst_operand  = operand_reg;
  assign inst_extended = extended_reg;
  assign parity_err    = parity_err_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table of single fetches plus hand
// sequences for backpressure restart, flush, parity error and memory timeout.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [11:0] pc_addr;
  logic        pc_enable;
  logic        flush;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  inst_opcode;
  logic [11:0] inst_operand;
  logic        inst_extended;
  logic        parity_err;
  logic        timeout_err;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .pc_addr      (pc_addr),
    .pc_enable    (pc_enable),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_opcode  (inst_opcode),
    .inst_operand (inst_operand),
    .inst_extended(inst_extended),
    .parity_err   (parity_err),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          ack_lat;
    int          ready_lat;
    int          exp_lat;
    logic [2:0]  op;
    logic [11:0] opnd;
    logic        ext;
    int          pulses;
    logic [11:0] addr;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] mem [64];
  int          ack_lat;
  logic        man_ack;
  logic [15:0] man_data;
  logic        jump_req;
  logic [11:0] jump_target;
  logic [11:0] last_addr;
  int          pc_pulses;
  int          n_vec;
  int          n_bad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Program counter model: increments on pc_enable, loads on a bench-driven jump.
  initial begin
    pc_addr   = '0;
    pc_pulses = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pc_addr   <= '0;
        pc_pulses <= 0;
      end else begin
        if (jump_req) pc_addr <= jump_target;
        else if (pc_enable) pc_addr <= pc_addr + 12'd1;
        if (pc_enable) pc_pulses <= pc_pulses + 1;
      end
    end
  end

  // Memory model: acks ack_lat cycles after REQ, or immediately when forced.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (man_ack) begin
        mem_ack  = 1'b1;
        mem_data = man_data;
        cnt      = 0;
      end else if (flush || !mem_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == ack_lat + 1) begin
          mem_ack   = 1'b1;
          mem_data  = mem[mem_addr[5:0]];
          last_addr = mem_addr;
        end
      end
    end
  end

  initial begin
    int lat;
    int p0;
    int n;

    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    //          w0        w1      ack rdy lat op    opnd    ext  pulses addr
    vecs[0] = '{16'hB005, 16'h0000, 1, 0, 3, 3'd3, 12'h005, 1'b0, 1, 12'd0};
    vecs[1] = '{16'h8006, 16'hB005, 1, 1, 6, 3'd3, 12'h005, 1'b1, 2, 12'd2};
    vecs[2] = '{16'h4123, 16'h0000, 3, 5, 5, 3'd4, 12'h123, 1'b0, 1, 12'd3};
    vecs[3] = '{16'h7FFF, 16'h0000, 2, 0, 4, 3'd7, 12'hFFF, 1'b0, 1, 12'd4};
    vecs[4] = '{16'h8006, 16'h8006, 1, 2, 6, 3'd0, 12'h006, 1'b1, 2, 12'd6};
    vecs[5] = '{16'h8000, 16'h0000, 1, 0, 3, 3'd0, 12'h000, 1'b0, 1, 12'd7};

    rst_n = 1'b0; run = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    ack_lat = 1; man_ack = 1'b0; man_data = '0; jump_req = 1'b0; jump_target = '0;
    repeat (3) @(negedge clk);
    check("reset_mem", {mem_req, mem_addr}, 13'd0);
    check("reset_inst", {inst_valid, inst_opcode, inst_operand, inst_extended}, 17'd0);
    check("reset_flags", {pc_enable, parity_err, timeout_err}, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_run", mem_req, 1'b0);

    for (int v = 0; v < 6; v++) begin
      mem[pc_addr[5:0]]               = vecs[v].w0;
      mem[6'(pc_addr[5:0] + 6'd1)]    = vecs[v].w1;
      ack_lat = vecs[v].ack_lat;
      p0      = pc_pulses;
      run     = 1'b1;
      @(negedge clk);
      run = 1'b0;
      lat = 0;
      while (!inst_valid && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check("latency", lat, vecs[v].exp_lat);
      check("opcode", inst_opcode, vecs[v].op);
      check("operand", inst_operand, vecs[v].opnd);
      check("extended", inst_extended, vecs[v].ext);
      check("pc_pulses", pc_pulses - p0, vecs[v].pulses);
      check("last_addr", last_addr, vecs[v].addr);
      for (int k = 0; k < vecs[v].ready_lat; k++) begin
        @(negedge clk);
        check("hold_stable", {inst_valid, mem_req, inst_opcode, inst_operand, inst_extended},
              {1'b1, 1'b0, vecs[v].op, vecs[v].opnd, vecs[v].ext});
      end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      check("released", inst_valid, 1'b0);
      $display("vec %0d: word=%h op=%0d operand=%h ext=%0d latency=%0d", v, vecs[v].w0,
               inst_opcode, inst_operand, inst_extended, lat);
    end

    // Accept with run=1 restarts the fetch on the very next cycle.
    mem[8] = 16'hB005;
    mem[9] = 16'h4123;
    run = 1'b1;
    n = 0;
    while (!inst_valid && n < 30) begin @(negedge clk); n++; end
    check("bp_valid", inst_valid, 1'b1);
    repeat (5) @(negedge clk);
    check("bp_stall", {inst_valid, mem_req, inst_opcode, inst_operand}, {1'b1, 1'b0, 3'd3, 12'h005});
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    run = 1'b0;
    check("bp_restart", {mem_req, inst_valid, mem_addr}, {1'b1, 1'b0, 12'd9});
    n = 0;
    while (!inst_valid && n < 30) begin @(negedge clk); n++; end
    check("bp_second", {inst_opcode, inst_operand}, {3'd4, 12'h123});
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    $display("seq backpressure: restart addr=9 second op=%0d", inst_opcode);

    // Flush in WAIT with a coincident ack, after an EXTEND has been absorbed.
    mem[10]     = 16'h8006;
    mem[6'h20]  = 16'hB005;
    ack_lat = 1;
    p0  = pc_pulses;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (pc_pulses == p0 && n < 20) begin @(negedge clk); n++; end
    ack_lat = 100;
    check("fl_req", {mem_req, mem_addr}, {1'b1, 12'd11});
    @(negedge clk);
    flush = 1'b1; man_ack = 1'b1; man_data = 16'hB005;
    jump_req = 1'b1; jump_target = 12'h020;
    @(negedge clk);
    flush = 1'b0; man_ack = 1'b0; jump_req = 1'b0; ack_lat = 1;
    check("fl_reissue", {mem_req, mem_addr}, {1'b1, 12'h020});
    check("fl_no_pulse", pc_pulses - p0, 1);
    lat = 0;
    while (!inst_valid && lat < 30) begin @(negedge clk); lat++; end
    check("fl_latency", lat, 3);
    check("fl_inst", {inst_opcode, inst_operand, inst_extended}, {3'd3, 12'h005, 1'b0});
    check("fl_pulses", pc_pulses - p0, 2);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    $display("seq flush: refetch addr=%h ext=%0d", last_addr, inst_extended);

    // Bad parity locks the stage in ERR until reset.
    mem[6'h21] = 16'h3005;
    p0  = pc_pulses;
    run = 1'b1;
    n = 0;
    while (!parity_err && n < 20) begin @(negedge clk); n++; end
    check("par_flag", {parity_err, timeout_err}, 2'b10);
    check("par_no_pulse", pc_pulses - p0, 0);
    for (int k = 0; k < 4; k++) begin
      flush = k[0];
      @(negedge clk);
      check("par_locked", {mem_req, inst_valid, pc_enable, parity_err}, 4'b0001);
    end
    flush = 1'b0;
    run   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("par_reset", {parity_err, timeout_err, mem_req}, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("seq parity: flag cleared by reset");

    // No ack at all: REQ plus 15 WAIT cycles, then timeout.
    @(negedge clk);
    ack_lat = 200;
    p0  = pc_pulses;
    run = 1'b1;
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin n++; @(negedge clk); end
    check("to_cycles", n, 16);
    check("to_flags", {timeout_err, parity_err, mem_req, pc_enable}, 4'b1000);
    check("to_no_pulse", pc_pulses - p0, 0);
    $display("seq timeout: mem_req cycles=%0d", n);

    run = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Reads the 12-bit PC address, issues a read to fixed/erasable memory, and checks AGC odd parity on the returned 16-bit word.
- Absorbs the EXTEND prefix, then hands a decoded opcode/operand to the decoder over a valid/ready handshake.
- Pulses the PC's enable exactly once per fetched word, so the PC advances only when a fetch completes.

Parameters:
- MEM_TIMEOUT, 15, number of WAIT cycles without mem_ack before a timeout error (range 1..255).
- EXTEND_WORD, 15'o00006, 15-bit data pattern of the EXTEND instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch permitted; gates the IDLE->REQ and HOLD->REQ transitions only.
- pc_addr  in  12  current address from the PC.
- pc_enable  out  1  one-cycle pulse to the PC enable; PC increments on that edge.
- flush  in  1  jump/redirect; discard the in-flight fetch.
- mem_req  out  1  memory read request.
- mem_addr  out  12  read address, stable while mem_req=1.
- mem_ack  in  1  memory data valid, single-cycle.
- mem_data  in  16  [15]=parity bit, [14:0]=data.
- inst_valid  out  1  instruction available to the decoder.
- inst_ready  in  1  decoder accepts the instruction.
- inst_opcode  out  3  data[14:12].
- inst_operand  out  12  data[11:0].
- inst_extended  out  1  instruction was preceded by EXTEND.
- parity_err  out  1  sticky parity-error flag.
- timeout_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; all outputs 0; ext_pending=0; timeout counter=0.
  - Reset mid-fetch abandons the fetch with no PC pulse.
- States: IDLE, REQ, WAIT, ADV, HOLD, ERR. All outputs are registered or Moore-decoded from the state.
- IDLE: go to REQ when run=1.
- REQ (1 cycle):
  - mem_addr <= pc_addr; mem_req=1; go to WAIT.
- WAIT:
  - mem_req=1 and mem_addr held; counter increments each cycle.
  - On mem_ack=1: latch mem_data, clear counter, go to ADV.
  - If the counter reaches MEM_TIMEOUT without mem_ack: timeout_err=1, go to ERR.
- ADV (1 cycle):
  - pc_enable=1.
  - Parity check: if XOR of mem_data[15:0] equals 0, parity_err=1, pc_enable=0, go to ERR.
  - Else if data==EXTEND_WORD and ext_pending=0: ext_pending<=1, go to REQ. The PC has advanced by the time REQ samples pc_addr.
  - Else: latch opcode/operand, inst_extended<=ext_pending, ext_pending<=0, go to HOLD.
- EXTEND EXTEND: a second EXTEND while ext_pending=1 is delivered as a normal instruction with inst_extended=1.
- HOLD:
  - inst_valid=1; outputs stable until accepted.
  - inst_valid&inst_ready: go to REQ if run=1, else IDLE.
- Minimum latency: entering REQ to inst_valid=1 is 3 cycles, with mem_ack in the first WAIT cycle.
- flush=1 in REQ/WAIT/ADV/HOLD:
  - Next state REQ; inst_valid drops next cycle; ext_pending<=0; counter cleared.
  - ADV still emits its pc_enable pulse that cycle.
  - A mem_ack arriving the same cycle as flush is ignored.
- flush in IDLE: no effect.
- flush with inst_ready in the same HOLD cycle: flush wins; the instruction is counted as discarded.
- ERR:
  - Terminal until reset; mem_req=0, inst_valid=0, pc_enable=0.
  - Flags stay set; flush and run are ignored.
- run=0 does not abort a fetch already in REQ/WAIT/ADV.

Test Plan:
- Reset, run=1, pc_addr=0, mem_ack one cycle after mem_req, mem_data=16'hB005 -> mem_addr=0; pc_enable single pulse; inst_valid 3 cycles after REQ; opcode=3, operand=12'h005, extended=0.
- EXTEND: mem_data=16'h8006 then 16'hB005 at addresses 0 and 1 -> two pc_enable pulses; second mem_addr=1; one inst_valid with extended=1, opcode=3.
- Backpressure: inst_ready=0 for 5 cycles -> inst_valid and fields stable, no new mem_req; inst_ready=1 -> REQ next cycle.
- Parity error: mem_data=16'h3005 -> parity_err=1, no pc_enable, mem_req stays 0 thereafter; rst_n=0 clears the flag.
- Timeout: mem_ack never asserted -> after 15 WAIT cycles timeout_err=1, mem_req=0; no pc_enable.
- Flush during WAIT, then mem_ack in the same cycle -> data discarded, no pc_enable, new REQ samples current pc_addr, ext_pending cleared.
